// File: rtl/bw_icache_fill_ctrl_pkg.sv
// rfBlackWidowPkg: shared I$ geometry and refill controller state encoding.
package rfBlackWidowPkg;
  typedef enum logic [1:0] {IDLE, FILL, TAGWR, RESTART} fill_state_e;
  localparam int ICACHE_LINE_BYTES = 128;
  localparam int ICACHE_BEATS = 8;
  localparam int ICACHE_IDX_LSB = $clog2(ICACHE_LINE_BYTES);
  localparam int ICACHE_IDX_MSB = 13;
  localparam int ICACHE_BEAT_W = $clog2(ICACHE_BEATS);
endpackage

// File: rtl/bw_icache_tagcmp.sv
// bw_icache_tagcmp: 4-way tag compare with lowest-way-wins priority encode.
module bw_icache_tagcmp #(
  parameter int TW = 25,
  parameter int WAYS = 4
) (
  input  logic [WAYS-1:0][TW-1:0] i_tag,
  input  logic [TW-1:0]           i_ref,
  output logic                    o_any,
  output logic [1:0]              o_way
);
  logic [WAYS-1:0] w_m;
  for (genvar g = 0; g < WAYS; g++) begin : g_cmp
    assign w_m[g] = i_tag[g] == i_ref;
  end
  assign o_any = |w_m;
  assign o_way = w_m[0] ? 2'd0 : w_m[1] ? 2'd1 : w_m[2] ? 2'd2 : 2'd3;
endmodule

// File: rtl/bw_icache_fill_ctrl.sv
// bw_icache_fill_ctrl: I$ hit detect plus 8-beat line refill; the tag is written
// only after the whole line has landed so a partial line can never hit.
module bw_icache_fill_ctrl
  import rfBlackWidowPkg::*;
#(
  parameter int AWID = 32,
  parameter int LINES = 128,
  parameter int WAYS = 4,
  parameter int BUSWID = 128
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   fetch_v,
  input  logic [AWID-1:0]                        fetch_ip,
  input  logic [WAYS-1:0][AWID-ICACHE_IDX_LSB-1:0] tag_i,
  output logic                                   hit_o,
  output logic [1:0]                             hit_way_o,
  output logic                                   stall_o,
  output logic                                   fault_o,
  output logic                                   cyc_o,
  output logic                                   stb_o,
  output logic [AWID-1:0]                        adr_o,
  input  logic                                   ack_i,
  input  logic                                   err_i,
  input  logic [BUSWID-1:0]                      dat_i,
  output logic                                   dwr_o,
  output logic [1:0]                             dway_o,
  output logic [$clog2(LINES)-1:0]               dline_o,
  output logic [ICACHE_BEAT_W-1:0]               dbeat_o,
  output logic [BUSWID-1:0]                      ddat_o,
  output logic                                   wr_o,
  output logic [AWID-1:0]                        ipo_o,
  output logic [1:0]                             way_o
);
  localparam int TW = AWID - ICACHE_IDX_LSB;
  localparam int LW = $clog2(LINES);
  localparam int OFF = ICACHE_IDX_LSB - ICACHE_BEAT_W;
  fill_state_e r_state, w_next;
  logic [AWID-1:0] r_ip;
  logic r_lk_v, r_fault;
  logic [ICACHE_BEAT_W-1:0] r_beat;
  logic [1:0] r_rr, w_way;
  logic w_any, w_miss, w_fill, w_ack, w_last, w_take;
  bw_icache_tagcmp #(.TW(TW), .WAYS(WAYS)) u_tagcmp (
    .i_tag(tag_i),
    .i_ref(r_ip[AWID-1:ICACHE_IDX_LSB]),
    .o_any(w_any),
    .o_way(w_way)
  );
  assign w_fill = r_state == FILL;
  assign hit_o = r_lk_v && w_any;
  assign hit_way_o = hit_o ? w_way : 2'd0;
  assign w_miss = r_lk_v && !w_any;
  assign stall_o = r_state != IDLE || w_miss;
  assign w_take = r_state == IDLE && fetch_v && !stall_o;
  assign w_ack = w_fill && ack_i && !err_i;
  assign w_last = r_beat == ICACHE_BEAT_W'(ICACHE_BEATS - 1);
  assign cyc_o = w_fill;
  assign stb_o = w_fill;
  assign adr_o = {r_ip[AWID-1:ICACHE_IDX_LSB], r_beat, {OFF{1'b0}}};
  assign dwr_o = w_ack;
  assign dway_o = r_rr;
  assign dline_o = r_ip[ICACHE_IDX_LSB +: LW];
  assign dbeat_o = r_beat;
  assign ddat_o = w_ack ? dat_i : '0;
  assign wr_o = r_state == TAGWR;
  assign ipo_o = r_ip;
  assign way_o = r_rr;
  assign fault_o = r_fault;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_miss ? FILL : IDLE) :
             w_fill ? (err_i ? IDLE : (w_ack && w_last) ? TAGWR : FILL) :
             r_state == TAGWR ? RESTART : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ip <= '0;
      r_lk_v <= 1'b0;
      r_fault <= 1'b0;
      r_beat <= '0;
      r_rr <= 2'd0;
    end else begin
      r_state <= w_next;
      r_lk_v <= w_take;
      if (w_take) r_ip <= fetch_ip;
      r_beat <= w_ack ? r_beat + ICACHE_BEAT_W'(1) : (w_fill && err_i) ? '0 : r_beat;
      r_rr <= wr_o ? r_rr + 2'd1 : r_rr;
      r_fault <= w_fill && err_i;
    end
  end
endmodule

// File: tb/tb_bw_icache_fill_ctrl.sv
// tb_bw_icache_fill_ctrl: random + directed fetches checked against a tag-array/replacement model.
module tb_bw_icache_fill_ctrl;
  logic clk = 0, rst_n = 0, fetch_v = 0, ack_i = 0, err_i = 0;
  logic [31:0] fetch_ip = 0;
  logic [3:0][24:0] tag_i = '0;
  logic [127:0] dat_i = '0;
  logic hit_o, stall_o, fault_o, cyc_o, stb_o, dwr_o, wr_o;
  logic [1:0] hit_way_o, dway_o, way_o;
  logic [31:0] adr_o, ipo_o;
  logic [6:0] dline_o;
  logic [2:0] dbeat_o;
  logic [127:0] ddat_o;
  int n_chk = 0, n_fail = 0;
  logic [24:0] m_tag [4][128];
  bit m_val [4][128];
  int m_rr = 0;
  logic [31:0] pool [$];

  bw_icache_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_v(fetch_v), .fetch_ip(fetch_ip), .tag_i(tag_i),
    .hit_o(hit_o), .hit_way_o(hit_way_o), .stall_o(stall_o), .fault_o(fault_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .ack_i(ack_i), .err_i(err_i),
    .dat_i(dat_i), .dwr_o(dwr_o), .dway_o(dway_o), .dline_o(dline_o), .dbeat_o(dbeat_o),
    .ddat_o(ddat_o), .wr_o(wr_o), .ipo_o(ipo_o), .way_o(way_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_way(input logic [31:0] ip);
    exp_way = -1;
    for (int w = 3; w >= 0; w--)
      if (m_val[w][ip[13:7]] && m_tag[w][ip[13:7]] == ip[31:7]) exp_way = w;
  endfunction

  task automatic set_tags(input logic [31:0] ip);
    for (int w = 0; w < 4; w++)
      tag_i[w] = m_val[w][ip[13:7]] ? m_tag[w][ip[13:7]] : ~ip[31:7];
  endtask

  task automatic do_fetch(input logic [31:0] ip, input int dly, input int err_beat, input int rst_beat);
    int hw, fault_n, dwr_n;
    logic [31:0] base;
    base = ip & 32'hFFFF_FF80;
    fault_n = 0;
    dwr_n = 0;
    @(negedge clk);
    fetch_v = 1;
    fetch_ip = ip;
    #1 chk("lookup_stall", stall_o, 0);
    @(negedge clk);
    set_tags(ip);
    hw = exp_way(ip);
    fetch_v = 0;
    if (hw < 0) begin
      fetch_v = 1'($urandom_range(0, 1));
      fetch_ip = $urandom;
    end
    #1 chk("hit", hit_o, hw >= 0);
    chk("miss_stall", stall_o, hw < 0);
    if (hw >= 0) begin
      chk("hit_way", hit_way_o, hw);
      chk("hit_cyc", cyc_o, 0);
      return;
    end
    for (int b = 0; b < 8; b++) begin
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        fetch_v = 0;
        ack_i = 0;
        err_i = 0;
        #1 chk("wait_stb", stb_o, 1);
        chk("wait_adr", adr_o, base + 32'(b * 16));
        chk("wait_stall", stall_o, 1);
        dwr_n += int'(dwr_o);
        fault_n += int'(fault_o);
      end
      @(negedge clk);
      fetch_v = 0;
      if (b == rst_beat) begin
        rst_n = 0;
        #1 chk("rst_cyc", cyc_o, 0);
        chk("rst_stb", stb_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_wr", wr_o, 0);
        m_rr = 0;
        @(negedge clk);
        rst_n = 1;
        return;
      end
      dat_i = {$urandom, $urandom, $urandom, $urandom};
      ack_i = 1;
      err_i = b == err_beat;
      #1 chk("cyc", cyc_o, 1);
      chk("adr", adr_o, base + 32'(b * 16));
      fault_n += int'(fault_o);
      if (b == err_beat) begin
        chk("err_dwr", dwr_o, 0);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          ack_i = 0;
          err_i = 0;
          #1 fault_n += int'(fault_o);
          chk("err_cyc", cyc_o, 0);
          chk("err_wr", wr_o, 0);
          chk("err_stall", stall_o, 0);
        end
        chk("fault_pulses", fault_n, 1);
        return;
      end
      chk("dwr", dwr_o, 1);
      chk("dway", dway_o, m_rr);
      chk("dline", dline_o, ip[13:7]);
      chk("dbeat", dbeat_o, b);
      chk("ddat", ddat_o, dat_i);
      dwr_n++;
    end
    @(negedge clk);
    ack_i = 0;
    #1 chk("tag_wr", wr_o, 1);
    chk("ipo", ipo_o, ip);
    chk("way", way_o, m_rr);
    chk("tag_cyc", cyc_o, 0);
    chk("tag_stall", stall_o, 1);
    chk("dwr_total", dwr_n, 8);
    chk("fill_fault", fault_n, 0);
    m_tag[m_rr][ip[13:7]] = ip[31:7];
    m_val[m_rr][ip[13:7]] = 1;
    m_rr = (m_rr + 1) % 4;
    @(negedge clk);
    #1 chk("restart_stall", stall_o, 1);
    chk("restart_wr", wr_o, 0);
  endtask

  initial begin
    logic [31:0] ip;
    #1 chk("rst_hit", hit_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_strobes", {fault_o, cyc_o, stb_o, dwr_o, wr_o}, 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_ipo", ipo_o, 0);
    chk("rst_ddat", ddat_o, 0);
    @(negedge clk);
    rst_n = 1;
    m_tag[2][5] = 25'h5;
    m_val[2][5] = 1;
    do_fetch(32'h0000_0280, 0, -1, -1);
    do_fetch(32'h1234_5680, 0, -1, -1);
    do_fetch(32'h1234_5680, 0, -1, -1);
    @(negedge clk);
    fetch_v = 1;
    fetch_ip = 32'h0000_0280;
    @(negedge clk);
    set_tags(32'h0000_0280);
    fetch_ip = 32'h1234_5680;
    #1 chk("b2b_hit0", hit_o, 1);
    chk("b2b_way0", hit_way_o, 2);
    @(negedge clk);
    fetch_v = 0;
    set_tags(32'h1234_5680);
    #1 chk("b2b_hit1", hit_o, 1);
    chk("b2b_way1", hit_way_o, 0);
    chk("b2b_stall", stall_o, 0);
    do_fetch(32'h7777_0100, 1, 3, -1);
    do_fetch(32'h7777_0100, 0, -1, -1);
    do_fetch(32'h5555_AA00, 5, -1, -1);
    do_fetch(32'h3333_0400, 0, -1, 4);
    do_fetch(32'h3333_0400, 0, -1, -1);
    for (int k = 1; k < 5; k++) do_fetch(32'hA000_0000 + 32'(k << 7), 0, -1, -1);
    chk("wrap_rr", m_rr, 1);
    for (int i = 0; i < 40; i++) begin
      ip = (pool.size() > 0 && $urandom_range(0, 1) == 1) ? pool[$urandom_range(0, pool.size() - 1)] : $urandom;
      pool.push_back(ip);
      do_fetch(ip, $urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : -1, -1);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/bw_icache_fill_ctrl.md
Name: bw_icache_fill_ctrl

Overview:
- Instruction-cache miss/refill controller for the BlackWidow fetch path.
- Compares the 4 tags returned by the I$ tag array against the registered fetch IP and flags hit/miss.
- On a miss, reads the 128-byte line from the bus as 8 single-beat read handshakes and writes each beat into the I$ data RAM.
- Writes the tag (wr/ipo/way) only after all 8 beats land, so a partially filled line never hits.

Parameters:
- AWID, 32, address width; tag field is [AWID-1:7].
- LINES, 128, lines per way; line index = ip[13:7].
- WAYS, 4, associativity; fixed at 4 in this revision.
- BUSWID, 128, bus data width; beats per line = 1024/BUSWID = 8.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_v  in  1  fetch request valid in this cycle.
- fetch_ip  in  AWID  fetch address (same value the tag array samples).
- tag_i  in  4x(AWID-7)  tags of ways 0..3, valid the cycle after fetch_v.
- hit_o  out  1  lookup hit, in the cycle after fetch_v.
- hit_way_o  out  2  hitting way, lowest index wins.
- stall_o  out  1  fetch must hold; controller is busy.
- fault_o  out  1  one-cycle pulse on bus error.
- cyc_o  out  1  bus cycle active for the whole fill.
- stb_o  out  1  beat request.
- adr_o  out  AWID  beat address.
- ack_i  in  1  beat accepted; dat_i valid.
- err_i  in  1  bus error; ends the fill.
- dat_i  in  BUSWID  beat data.
- dwr_o  out  1  data RAM write strobe.
- dway_o  out  2  data RAM way.
- dline_o  out  7  data RAM line index.
- dbeat_o  out  3  beat within line.
- ddat_o  out  BUSWID  beat data to RAM.
- wr_o  out  1  tag array write.
- ipo_o  out  AWID  tag write address/value.
- way_o  out  2  tag write way.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All strobes are 0: hit_o, stall_o, fault_o, cyc_o, stb_o, dwr_o, wr_o.
  - adr_o, ipo_o, ddat_o and indices are 0; replacement counter rr = 0.
  - Reset asserted mid-fill drops cyc_o immediately, writes no tag, and the partial line stays invisible.
- Lookup, cycle N: in IDLE with fetch_v=1, the controller registers ip_q=fetch_ip and sets lk_v=1.
- Cycle N+1: hit_o = lk_v && any(tag_i[w] == ip_q[AWID-1:7]); hit_way_o = lowest matching w.
  - On a hit, no state change.
  - On a miss, go to FILL and assert stall_o combinationally in N+1.
- FILL:
  - cyc_o=1 and stb_o=1; adr_o = {ip_q[AWID-1:7], beat, 4'b0000}, with beat starting at 0.
  - On ack_i: dwr_o=1 in the same cycle with dway_o=rr, dline_o=ip_q[13:7], dbeat_o=beat, ddat_o=dat_i; then beat increments.
  - On ack_i with beat==7: go to TAGWR and drop stb_o/cyc_o next cycle.
  - err_i (takes priority over a simultaneous ack_i): go to IDLE, pulse fault_o for 1 cycle, no tag write, rr unchanged.
- TAGWR, 1 cycle: wr_o=1, ipo_o=ip_q, way_o=rr; rr increments mod 4 (2-bit wrap 3->0); go to RESTART.
- RESTART, 1 cycle: stall_o=1 and lk_v=0, so the tag array settles after the write; go to IDLE.
  - Fetch re-issues, and the re-lookup hits (2-cycle refetch latency after TAGWR).
- stall_o = 1 in FILL, TAGWR and RESTART, and in the miss-detect cycle; fetch_v is ignored while stall_o=1.
- A fetch_v in the same cycle a miss is detected is dropped; fetch must replay.
- Back-to-back hits: one lookup per cycle, no bubbles.
- Multiple matching ways (should not occur) resolve to the lowest index.

Decomposition:
- Shared package (rfBlackWidowPkg): the state enum (IDLE, FILL, TAGWR, RESTART); ICACHE_LINE_BYTES=128; ICACHE_BEATS=8; ICACHE_IDX_LSB=7; ICACHE_IDX_MSB=13.
- One natural sub-module: bw_icache_tagcmp, the 4-way tag compare plus priority encoder (combinational), reused by the data-cache side later.

Test Plan:
- Hit: preload way 2 line 0x05 with tag for ip=0x0000_0280; fetch_v with that ip -> next cycle hit_o=1, hit_way_o=2, stall_o=0, cyc_o stays 0.
- Miss and fill: fetch ip=0x1234_5680 with all ways mismatching -> stall_o=1, adr_o=0x1234_5680..0x1234_56F0 in steps of 0x10; dwr_o pulses 8 times with dbeat_o 0..7, dline_o=0x2D, dway_o=0.
  - Then wr_o=1, ipo_o=0x1234_5680, way_o=0; re-fetch hits way 0.
- Replacement wrap: 5 consecutive misses -> way_o sequence 0,1,2,3,0.
- Bus error: err_i on beat 3 -> fault_o pulses once, wr_o never asserts, next miss still uses the same way, and a re-fetch of that ip misses again.
- Ack stalls: ack_i withheld 5 cycles per beat -> stb_o and adr_o held stable until ack, no extra dwr_o, and exactly 8 writes total.
- Reset mid-fill: rst_n low at beat 4 -> cyc_o/stb_o/stall_o drop immediately; after release, a re-fetch of that ip misses and starts a fresh fill at beat 0, way 0.
